fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Final stage of the io881 transmit path, directly downstream of the last FIFO element. It looks like a FIFO element to its upstream neighbour: it captures a word on `d_in_strobe` when empty and reports occupancy on `used`, which drives the tail element's `next_used`. It then serialises the word onto `txd` as an asynchronous frame: start bit, data LSB first, optional parity, one stop bit. `used` stays high until the stop bit completes.

## Interface
Parameters:
- `WIDTH`, 8, data bits per frame and width of `d_in`.
- `DIV_WIDTH`, 16, width of the bit-period divisor.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d_in`  in  WIDTH  word offered by the tail FIFO element.
- `d_in_strobe`  in  1  upstream offers `d_in`; sampled on the `clk` rising edge.
- `used`  out  1  stage occupied; wired to the tail element's `next_used`.
- `divisor`  in  DIV_WIDTH  bit period minus one, in `clk` cycles.
- `parity_en`  in  1  insert a parity bit after the data bits.
- `parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `txd`  out  1  serial line; idles high.

## Operation
- Reset values: `used`=0, `txd`=1, state IDLE, shift register 0, bit counter 0, period counter 0.
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `txd`=1 and `used`=0. On an edge with `d_in_strobe`=1, the block:
  - latches `d_in`, `divisor`, `parity_en` and `parity_odd`;
  - moves to START.
- **START:** `txd`=0 for one bit period, then DATA.
- **DATA:** `txd`=shift[0].
  - At each bit-period end the register shifts right and the bit counter increments.
  - After WIDTH bits, go to PARITY if the latched `parity_en`=1, else STOP.
- **PARITY:** `txd` = XOR of the latched data, inverted when `parity_odd`=1. Lasts one bit period, then STOP.
- **STOP:** `txd`=1 for one bit period, then IDLE.
- `used` = (state != IDLE). It is registered and changes on the same edges as the state.
- A strobe while `used`=1 is ignored. The word is not latched and the frame is not disturbed; upstream holds it because `next_used`=1.
- Divisor and parity settings are frozen per frame. Changing them mid-frame affects only the next frame.
- Period counter: loads the latched divisor at each bit start and counts down. The bit ends when it reaches 0 at an edge. `divisor`=0 gives 1-clock bits.
- `rst_n` asserted mid-frame: `txd`=1 and `used`=0 immediately (asynchronous). The frame is aborted and the word lost.

## Timing
- Strobe sampled at edge N: `txd` falls and `used` rises after edge N (zero-cycle capture latency).
- Bit period P = latched divisor + 1 cycles. Frame length F = (2 + WIDTH + parity_en) × P cycles.
- `txd` data bit k occupies edges N+(1+k)P to N+(2+k)P.
- `used` falls after edge N+F, so the earliest next capture is edge N+F+1. Back-to-back frames therefore have one idle (high) clock between them.
- `used` is registered, giving the tail element a glitch-free `next_used`.
- Outputs never go X or Z after reset; `txd` changes only on `clk` edges, except at reset.

## Structure
- Shared package `fifo_serial_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - `TXD_IDLE`=1 and `TXD_START`=0 constants;
  - the default `WIDTH` and `DIV_WIDTH`.
- One sub-module, `fifo_baud_counter`: a loadable down-counter with `load`, `load_value[DIV_WIDTH]` and a `tick` output asserted when it reaches 0.
- Everything else (FSM, shift register, bit counter, parity) lives in `fifo_serial_tx`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 clocks -> `used`=0, `txd`=1. Release with no strobe for 10 clocks -> outputs unchanged.
- **Basic frame:** `divisor`=3, parity off, strobe `d_in`=8'hA5 for one clock -> `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held for 4 clocks. `used` is high for exactly 40 clocks.
- **Parity:** `divisor`=0, `parity_en`=1, strobe 8'h07 ->
  - `parity_odd`=0: parity bit 1;
  - `parity_odd`=1: parity bit 0;
  - frame is 11 clocks in both cases.
- **Busy rejection:** strobe 8'hAA, then strobe 8'h55 two clocks later while `used`=1 -> the serialised frame is 8'hAA only. The second word is transmitted only if re-strobed after `used` falls.
- **Back-to-back:** strobe asserted continuously with new data each time `used`=0 -> one idle-high clock between frames, and both words are correct.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 -> `txd`=1 and `used`=0 within the same cycle. After release, a new strobe of 8'h3C produces a complete correct frame.

Source files
------------

// File: rtl/fifo_serial_pkg.sv
// Shared definitions for the io881 serial transmit stage: state encoding,
// line levels and default widths.
package fifo_serial_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_DIV_WIDTH = 16;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic TXD_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_baud_counter.sv
// Loadable bit-period down-counter; tick is high while the count sits at zero,
// so a bit ends on the edge where the counter has already reached zero.
module fifo_baud_counter
  import fifo_serial_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_value,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tick = (r_count == '0);

endmodule

// File: rtl/fifo_serial_tx.sv
// Final FIFO element of the io881 transmit path: accepts one word when empty
// and serialises it as start, data LSB first, optional parity, stop.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 d_in_strobe,
  output logic                 used,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 txd
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  tx_state_e            r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DIV_WIDTH-1:0] r_divisor;
  logic                 r_parity_en;
  logic                 r_parity_odd;
  logic                 r_data_xor;
  logic                 r_txd;
  logic                 r_used;

  logic                 w_capture;
  logic                 w_tick;
  logic                 w_load;
  logic [DIV_WIDTH-1:0] w_load_value;
  logic                 w_last_bit;

  assign w_capture    = (r_state == IDLE) && d_in_strobe;
  assign w_load       = w_capture || ((r_state != IDLE) && w_tick);
  // The capture edge loads the live divisor, since it is being latched on that same edge.
  assign w_load_value = (r_state == IDLE) ? divisor : r_divisor;
  assign w_last_bit   = (r_bit_cnt == CNT_W'(WIDTH - 1));

  fifo_baud_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .load_value(w_load_value),
    .tick      (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_divisor    <= '0;
      r_parity_en  <= 1'b0;
      r_parity_odd <= 1'b0;
      r_data_xor   <= 1'b0;
      r_txd        <= TXD_IDLE;
      r_used       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (d_in_strobe) begin
            r_shift      <= d_in;
            r_divisor    <= divisor;
            r_parity_en  <= parity_en;
            r_parity_odd <= parity_odd;
            r_data_xor   <= ^d_in;
            r_bit_cnt    <= '0;
            r_txd        <= TXD_START;
            r_used       <= 1'b1;
            r_state      <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (!w_last_bit) begin
              r_txd <= r_shift[1];
            end else if (r_parity_en) begin
              r_txd   <= r_data_xor ^ r_parity_odd;
              r_state <= PARITY;
            end else begin
              r_txd   <= TXD_IDLE;
              r_state <= STOP;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_txd   <= TXD_IDLE;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_used  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_txd   <= TXD_IDLE;
          r_used  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign txd  = r_txd;
  assign used = r_used;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: table of hand-computed frames plus
// sequences for busy rejection, continuous strobe and mid-frame reset.
module tb_fifo_serial_tx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  d_in;
  logic        d_in_strobe;
  logic        used;
  logic [15:0] divisor;
  logic        parity_en;
  logic        parity_odd;
  logic        txd;

  int n_checks = 0;
  int n_errors = 0;

  // exp_bits[k] is the k-th line level of the frame (bit 0 = start bit).
  typedef struct {
    logic [7:0]  data;
    logic [15:0] divisor;
    logic        par_en;
    logic        par_odd;
    logic [10:0] exp_bits;
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  fifo_serial_tx #(.WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .d_in_strobe(d_in_strobe),
    .used       (used),
    .divisor    (divisor),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .txd        (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge. Strobes v for one edge, then checks every cycle of the
  // frame plus the idle cycle after it. Settings are scrambled after capture.
  task automatic run_frame(input vec_t v, input bit inject, input bit keep, input logic [7:0] next_d);
    int p;
    p           = int'(v.divisor) + 1;
    d_in        = v.data;
    divisor     = v.divisor;
    parity_en   = v.par_en;
    parity_odd  = v.par_odd;
    d_in_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    divisor    = v.divisor + 16'd5;
    parity_en  = ~v.par_en;
    parity_odd = ~v.par_odd;
    if (keep) d_in = next_d;
    else      d_in_strobe = 1'b0;
    for (int j = 0; j < v.exp_len; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("txd d=%02h cyc%0d", v.data, j), {31'd0, txd}, {31'd0, v.exp_bits[j / p]});
      check($sformatf("used d=%02h cyc%0d", v.data, j), {31'd0, used}, 32'd1);
      if (inject && j == 1) begin
        d_in        = 8'h55;
        d_in_strobe = 1'b1;
      end
      if (inject && j == 2) d_in_strobe = 1'b0;
    end
    @(negedge clk);
    check($sformatf("used end d=%02h", v.data), {31'd0, used}, 32'd0);
    check($sformatf("txd end d=%02h", v.data), {31'd0, txd}, 32'd1);
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 11'h34A, 40};
    vecs[1] = '{8'h07, 16'd0, 1'b1, 1'b0, 11'h60E, 11};
    vecs[2] = '{8'h07, 16'd0, 1'b1, 1'b1, 11'h40E, 11};
    vecs[3] = '{8'h3C, 16'd1, 1'b1, 1'b0, 11'h478, 22};
    vecs[4] = '{8'hFF, 16'd2, 1'b1, 1'b1, 11'h7FE, 33};
    vecs[5] = '{8'h00, 16'd0, 1'b0, 1'b0, 11'h200, 10};

    rst_n       = 1'b0;
    d_in        = 8'h00;
    d_in_strobe = 1'b0;
    divisor     = 16'd0;
    parity_en   = 1'b0;
    parity_odd  = 1'b0;

    // Reset held for 3 clocks, then 10 idle clocks
    repeat (3) @(negedge clk);
    check("reset used", {31'd0, used}, 32'd0);
    check("reset txd", {31'd0, txd}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle used %0d", i), {31'd0, used}, 32'd0);
      check($sformatf("idle txd %0d", i), {31'd0, txd}, 32'd1);
    end

    foreach (vecs[i]) run_frame(vecs[i], 1'b0, 1'b0, 8'h00);

    // Busy rejection: 8'h55 strobed two clocks into the 8'hAA frame
    v = '{8'hAA, 16'd0, 1'b0, 1'b0, 11'h354, 10};
    run_frame(v, 1'b1, 1'b0, 8'h00);
    v = '{8'h55, 16'd0, 1'b0, 1'b0, 11'h2AA, 10};
    run_frame(v, 1'b0, 1'b0, 8'h00);

    // Continuous strobe: next word captured one idle clock after used falls
    v = '{8'h81, 16'd1, 1'b0, 1'b0, 11'h302, 20};
    run_frame(v, 1'b0, 1'b1, 8'h7E);
    check("b2b used low between frames", {31'd0, used}, 32'd0);
    v = '{8'h7E, 16'd1, 1'b0, 1'b0, 11'h2FC, 20};
    run_frame(v, 1'b0, 1'b0, 8'h00);

    // Reset during data bit 3 of 8'hF0 (a 0 bit), divisor 3
    d_in        = 8'hF0;
    divisor     = 16'd3;
    parity_en   = 1'b0;
    parity_odd  = 1'b0;
    d_in_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_in_strobe = 1'b0;
    repeat (17) @(negedge clk);
    check("pre-reset txd bit3", {31'd0, txd}, 32'd0);
    check("pre-reset used", {31'd0, used}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset txd", {31'd0, txd}, 32'd1);
    check("async reset used", {31'd0, used}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{8'h3C, 16'd3, 1'b0, 1'b0, 11'h278, 40};
    run_frame(v, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
